// File: rtl/block_loader.sv
// -----------------------------------------------------------------------------
// block_loader
//
// Collects a block of 4*MATRIX_DIM element words from a valid/ready word
// stream into four row registers (Br_m1, Br_m2, Bi_m1, Bi_m2). It then
// presents the block to the select stage twice: first as a REAL_SET pass,
// then as a CROSS_SET pass. A block is committed to the visible row registers
// only when it is framed correctly. A framing error discards the partial
// block, leaves the rows untouched, and pulses err for one cycle.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   in_word    incoming element word (WORD_LEN bits)
//   in_valid   in_word is valid this cycle
//   in_last    sender's final word of the block (qualified by in_valid)
//   in_ready   loader accepts a word this cycle (asserted in LOAD only)
//   Br_m1, Br_m2, Bi_m1, Bi_m2
//              assembled row blocks (ROW_W bits each); element k of a row is
//              at bits [k*WORD_LEN +: WORD_LEN]
//   state      pass select: 0 = REAL_SET, 1 = CROSS_SET
//   out_valid  rows and state are valid for the select stage
//   out_ready  select stage consumes the current pass
//   err        one-cycle pulse on a framing error
//   blk_cnt    completed blocks (both passes), modulo 256
//
// Every output comes from a register or is decoded from the FSM state
// register. No input reaches an output combinationally.
// -----------------------------------------------------------------------------
module block_loader #(
  parameter  int WORD_LEN   = 16,
  parameter  int MATRIX_DIM = 4,
  localparam int ROW_W      = WORD_LEN * MATRIX_DIM,
  localparam int NWORDS     = 4 * MATRIX_DIM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_LEN-1:0] in_word,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [ROW_W-1:0]    Br_m1,
  output logic [ROW_W-1:0]    Br_m2,
  output logic [ROW_W-1:0]    Bi_m1,
  output logic [ROW_W-1:0]    Bi_m2,
  output logic                state,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                err,
  output logic [7:0]          blk_cnt
);

  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int BLK_W = NWORDS * WORD_LEN;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    LOAD       = 2'd0,
    PASS_REAL  = 2'd1,
    PASS_CROSS = 2'd2
  } fsm_state_e;

  fsm_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  // The word index selects the bit slice directly: word idx lives at
  // bits [idx*WORD_LEN +: WORD_LEN]. This gives row = idx/MATRIX_DIM and
  // element = idx%MATRIX_DIM without any explicit divide.
  logic [BLK_W-1:0] stage_q, stage_d;
  logic [BLK_W-1:0] rows_q, rows_d;
  logic             err_q, err_d;
  logic [7:0]       blk_cnt_q, blk_cnt_d;

  // Next-state logic
  // NOTE: every variable gets a default before the case statement. Without
  //       the defaults, any path that skips an assignment would infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    stage_d   = stage_q;
    rows_d    = rows_q;
    err_d     = 1'b0;
    blk_cnt_d = blk_cnt_q;

    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          stage_d[idx_q*WORD_LEN +: WORD_LEN] = in_word;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (in_last) begin
              // Commit the full block, final word included, in the same edge
              // that leaves LOAD. The rows change only on a good block.
              rows_d  = stage_d;
              state_d = PASS_REAL;
            end else begin
              err_d = 1'b1;
            end
          end else if (in_last) begin
            // Early end of block: drop the partial block.
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PASS_REAL: begin
        if (out_ready) state_d = PASS_CROSS;
      end
      PASS_CROSS: begin
        if (out_ready) begin
          state_d   = LOAD;
          blk_cnt_d = blk_cnt_q + 8'd1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Control and visible state
  // NOTE: sequential state uses non-blocking assignments. Every register then
  //       samples the pre-edge values, with no race between flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      idx_q     <= '0;
      rows_q    <= '0;
      err_q     <= 1'b0;
      blk_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rows_q    <= rows_d;
      err_q     <= err_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  // NOTE: the staging buffer is deliberately left without reset. Every slot
  //       is rewritten before a block can commit, so its power-up contents are
  //       never visible.
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q != LOAD);
  assign state     = (state_q == PASS_CROSS);
  assign err       = err_q;
  assign blk_cnt   = blk_cnt_q;

  assign Br_m1 = rows_q[0*ROW_W +: ROW_W];
  assign Br_m2 = rows_q[1*ROW_W +: ROW_W];
  assign Bi_m1 = rows_q[2*ROW_W +: ROW_W];
  assign Bi_m2 = rows_q[3*ROW_W +: ROW_W];

endmodule

// File: tb/tb_block_loader.sv
// -----------------------------------------------------------------------------
// tb_block_loader
//
// Directed bench for block_loader with WORD_LEN=16 and MATRIX_DIM=4.
// A table of per-cycle vectors covers the early-in_last framing error.
// Hand-written sequences cover the multi-cycle cases: a clean block, a
// back-pressure hold, a missing in_last, reset during a pass, and the
// blk_cnt wrap.
// -----------------------------------------------------------------------------
module tb_block_loader;

  logic        clk;
  logic        rst;
  logic [15:0] in_word;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [63:0] Br_m1, Br_m2, Bi_m1, Bi_m2;
  logic        state;
  logic        out_valid;
  logic        out_ready;
  logic        err;
  logic [7:0]  blk_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  block_loader #(.WORD_LEN(16), .MATRIX_DIM(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .Br_m1     (Br_m1),
    .Br_m2     (Br_m2),
    .Bi_m1     (Bi_m1),
    .Bi_m2     (Bi_m2),
    .state     (state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .blk_cnt   (blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic        valid;
    logic        last;
    logic        exp_err;
    logic        exp_in_ready;
    logic        exp_out_valid;
  } vec_t;

  vec_t vecs[9];

  localparam logic [63:0] ROW_A0 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] ROW_A1 = 64'h0008_0007_0006_0005;
  localparam logic [63:0] ROW_A2 = 64'h000C_000B_000A_0009;
  localparam logic [63:0] ROW_A3 = 64'h0010_000F_000E_000D;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send NWORDS=16 words base..base+15, raising in_last on word index
  // last_at (-1 means in_last is never raised).
  task automatic load_block(input logic [15:0] base, input int last_at);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_word  = base + 16'(i);
      in_last  = (i == last_at);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_rows(input string tag, input logic [63:0] r0,
                            input logic [63:0] r1, input logic [63:0] r2,
                            input logic [63:0] r3);
    check({tag, ".Br_m1"}, Br_m1, r0);
    check({tag, ".Br_m2"}, Br_m2, r1);
    check({tag, ".Bi_m1"}, Bi_m1, r2);
    check({tag, ".Bi_m2"}, Bi_m2, r3);
  endtask

  initial begin
    // Early in_last on the 7th word, then two idle cycles.
    for (int i = 0; i < 6; i++)
      vecs[i] = '{16'(i + 1), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16'h0007, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{16'h0055, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst       = 1'b1;
    in_word   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.state", 64'(state), 64'd0);
    check("rst.err", 64'(err), 64'd0);
    check("rst.blk_cnt", 64'(blk_cnt), 64'd0);
    check_rows("rst", 64'd0, 64'd0, 64'd0, 64'd0);

    // Table: early in_last framing error
    for (int v = 0; v < 9; v++) begin
      in_word  = vecs[v].word;
      in_valid = vecs[v].valid;
      in_last  = vecs[v].last;
      step();
      check($sformatf("vec%0d.err", v), 64'(err), 64'(vecs[v].exp_err));
      check($sformatf("vec%0d.in_ready", v), 64'(in_ready),
            64'(vecs[v].exp_in_ready));
      check($sformatf("vec%0d.out_valid", v), 64'(out_valid),
            64'(vecs[v].exp_out_valid));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_rows("early_err", 64'd0, 64'd0, 64'd0, 64'd0);

    // Clean block A after the error; one-cycle latency to out_valid
    load_block(16'h0001, 15);
    check("A.out_valid", 64'(out_valid), 64'd1);
    check("A.state", 64'(state), 64'd0);
    check("A.in_ready", 64'(in_ready), 64'd0);
    check("A.err", 64'(err), 64'd0);
    check_rows("A", ROW_A0, ROW_A1, ROW_A2, ROW_A3);

    // Back-pressure for 5 cycles, with in_valid ignored meanwhile
    in_valid = 1'b1;
    in_word  = 16'hDEAD;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("hold%0d.out_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("hold%0d.state", c), 64'(state), 64'd0);
      check($sformatf("hold%0d.in_ready", c), 64'(in_ready), 64'd0);
      check($sformatf("hold%0d.Br_m1", c), Br_m1, ROW_A0);
      check($sformatf("hold%0d.Bi_m2", c), Bi_m2, ROW_A3);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    // Both passes on consecutive cycles
    out_ready = 1'b1;
    step();
    check("A.cross.state", 64'(state), 64'd1);
    check("A.cross.out_valid", 64'(out_valid), 64'd1);
    check("A.cross.Bi_m1", Bi_m1, ROW_A2);
    step();
    check("A.done.out_valid", 64'(out_valid), 64'd0);
    check("A.done.in_ready", 64'(in_ready), 64'd1);
    check("A.done.blk_cnt", 64'(blk_cnt), 64'd1);
    out_ready = 1'b0;

    // 16 words with no in_last: err pulse, rows keep block A
    load_block(16'h0100, -1);
    check("nolast.err", 64'(err), 64'd1);
    check("nolast.out_valid", 64'(out_valid), 64'd0);
    check("nolast.in_ready", 64'(in_ready), 64'd1);
    check_rows("nolast", ROW_A0, ROW_A1, ROW_A2, ROW_A3);
    step();
    check("nolast.err_clear", 64'(err), 64'd0);

    // Index was cleared: the next block lands aligned
    load_block(16'h0020, 15);
    check("B.out_valid", 64'(out_valid), 64'd1);
    check_rows("B", 64'h0023_0022_0021_0020, 64'h0027_0026_0025_0024,
               64'h002B_002A_0029_0028, 64'h002F_002E_002D_002C);
    out_ready = 1'b1;
    step();
    check("B.cross.state", 64'(state), 64'd1);

    // Reset during PASS_CROSS
    out_ready = 1'b0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    check("rstx.out_valid", 64'(out_valid), 64'd0);
    check("rstx.state", 64'(state), 64'd0);
    check("rstx.err", 64'(err), 64'd0);
    check("rstx.blk_cnt", 64'(blk_cnt), 64'd0);
    check("rstx.in_ready", 64'(in_ready), 64'd1);
    check_rows("rstx", 64'd0, 64'd0, 64'd0, 64'd0);

    // 256 clean blocks at NWORDS+2 cycles each: blk_cnt wraps to 0
    out_ready = 1'b1;
    for (int b = 1; b <= 256; b++) begin
      load_block(16'h0001, 15);
      step();
      step();
      if (b == 1)   check("wrap.b1", 64'(blk_cnt), 64'd1);
      if (b == 255) check("wrap.b255", 64'(blk_cnt), 64'd255);
    end
    check("wrap.b256", 64'(blk_cnt), 64'd0);
    check("wrap.in_ready", 64'(in_ready), 64'd1);
    check("wrap.Bi_m2", Bi_m2, ROW_A3);
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/block_loader.md
BLOCK_LOADER -- requirements
Module: block_loader

Interface
REQ-001 SHALL have parameter WORD_LEN, default 16, giving the bit width of one matrix element word.
REQ-002 SHALL have parameter MATRIX_DIM, default 4, giving the number of words per row block.
REQ-003 SHALL define ROW_W = WORD_LEN*MATRIX_DIM and NWORDS = 4*MATRIX_DIM as derived widths/counts.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_word  input  WORD_LEN  incoming element word.
REQ-007 in_valid  input  1  in_word is valid this cycle.
REQ-008 in_last  input  1  marks the sender's final word of a block; qualified by in_valid.
REQ-009 in_ready  output  1  block accepts a word this cycle.
REQ-010 Br_m1, Br_m2, Bi_m1, Bi_m2  output  ROW_W each  assembled row blocks for the select stage.
REQ-011 state  output  1  pass select: 0 = REAL_SET (direct pairing), 1 = CROSS_SET (imaginary crossed).
REQ-012 out_valid  output  1  rows and state are valid for the select stage.
REQ-013 out_ready  input  1  select stage consumes the current pass.
REQ-014 err  output  1  one-cycle pulse on a framing error.
REQ-015 blk_cnt  output  8  count of completed blocks (both passes done), modulo 256.

Function
REQ-016 SHALL implement FSM states LOAD, PASS_REAL, PASS_CROSS.
REQ-017 In LOAD: in_ready=1, out_valid=0; a word is accepted when in_valid && in_ready.
REQ-018 Word order SHALL be Br_m1, Br_m2, Bi_m1, Bi_m2, each MATRIX_DIM words, element k at bits [k*WORD_LEN +: WORD_LEN].
REQ-019 A word index counter (0..NWORDS-1) SHALL increment per accepted word; row = idx/MATRIX_DIM, element = idx%MATRIX_DIM.
REQ-020 Accepting word idx = NWORDS-1 with in_last=1 SHALL transition to PASS_REAL on the next cycle and clear the index.
REQ-021 Accepting in_last=1 at idx < NWORDS-1 SHALL pulse err for one cycle, discard the partial block (index to 0, rows unchanged), and stay in LOAD.
REQ-022 Accepting idx = NWORDS-1 with in_last=0 SHALL pulse err, discard the block, and stay in LOAD with index 0.
REQ-023 In PASS_REAL: out_valid=1, state=0, in_ready=0; on out_ready=1, go to PASS_CROSS.
REQ-024 In PASS_CROSS: out_valid=1, state=1, in_ready=0; on out_ready=1, go to LOAD and increment blk_cnt (255 wraps to 0).
REQ-025 Row outputs SHALL be registered and held stable from entry into PASS_REAL through exit from PASS_CROSS.
REQ-026 While out_valid=1 and out_ready=0, every output SHALL hold its value indefinitely.
REQ-027 Row registers SHALL update only in LOAD; they are never visible mid-write because out_valid=0 in LOAD.
REQ-028 in_valid while in_ready=0 SHALL be ignored (the sender must hold the word).
REQ-029 Minimum latency from the last accepted word to out_valid=1 SHALL be 1 cycle; each pass SHALL last at least 1 cycle; throughput is NWORDS+2 cycles per block.
REQ-030 All outputs SHALL be driven from registers or from the FSM state only, with no combinational path from any input.

Reset
REQ-031 rst=1 at a clock edge SHALL force LOAD, index=0, all rows=0, state=0, out_valid=0, err=0, blk_cnt=0; in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-032 rst asserted mid-load or mid-pass SHALL abandon the block with no err pulse and no blk_cnt increment.

Verification (WORD_LEN=16, MATRIX_DIM=4)
REQ-033 Stream words 0x0001..0x0010, in_last on the 16th word, out_ready=1 -> Br_m1=0x0004_0003_0002_0001, Bi_m2=0x0010_000F_000E_000D, state 0 then 1 on consecutive cycles, blk_cnt=1.
REQ-034 Same stream with out_ready=0 for 5 cycles -> out_valid=1 and state=0 hold, rows unchanged; in_ready=0 throughout.
REQ-035 in_last on the 7th word -> err pulses 1 cycle, no out_valid; the next clean 16-word block completes normally.
REQ-036 16 words with no in_last -> err pulses after word 16, FSM stays in LOAD, idx=0.
REQ-037 rst during PASS_CROSS -> next cycle out_valid=0, rows=0, blk_cnt unchanged from 0; 256 clean blocks -> blk_cnt wraps to 0.
